// File: rtl/sram_like_arbiter_pkg.sv
// Shared types for the sram-like slave-port arbiter.
// Owner IDs, grant FSM encodings and the per-master command bundle.
package sram_like_arbiter_pkg;

    localparam logic ARB_OWNER_INST = 1'b0;
    localparam logic ARB_OWNER_DATA = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_LOCK_INST = 2'd1,
        ARB_LOCK_DATA = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_cmd_t;

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// In-order owner tracker: 1-bit entries, DEPTH deep, pointers wrap at DEPTH.
// Push is ignored while full and pop while empty.
module arb_owner_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // storage, pointers and occupancy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wrap_inc(wptr);
            end
            if (do_pop) begin
                rptr <= wrap_inc(rptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Arbitrates IF and MEM sram-like masters onto one slave port.
// Define SRAM_ARB_RR_EN for round-robin contention; default is data-first.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        sram_req,
    output logic        sram_wr,
    output logic [1:0]  sram_size,
    output logic [3:0]  sram_wstrb,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic        sram_addr_ok,
    input  logic        sram_data_ok,
    input  logic [31:0] sram_rdata
);

    arb_state_t state_q;
    arb_state_t state_d;
    sram_cmd_t  inst_cmd;
    sram_cmd_t  data_cmd;
    sram_cmd_t  gnt_cmd;
    logic       gnt_vld;
    logic       gnt_owner;
    logic       rr_pick;
    logic       full;
    logic       empty;
    logic       head;
    logic       push;
    logic       pop;

    assign inst_cmd = '{inst_req, inst_wr, inst_size,
                        inst_wstrb, inst_addr, inst_wdata};
    assign data_cmd = '{data_req, data_wr, data_size,
                        data_wstrb, data_addr, data_wdata};

`ifdef SRAM_ARB_RR_EN
    logic last_q;

    // remember who won the most recent accepted request
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_q <= ARB_OWNER_INST;
        end else if (push) begin
            last_q <= gnt_owner;
        end
    end

    assign rr_pick = ~last_q;
`else
    assign rr_pick = ARB_OWNER_DATA;
`endif

    // grant FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // grant selection and lock transitions; a lock ends on accept or req drop
    always_comb begin
        state_d   = state_q;
        gnt_vld   = 1'b0;
        gnt_owner = ARB_OWNER_DATA;
        unique case (state_q)
            ARB_LOCK_INST: begin
                gnt_vld   = 1'b1;
                gnt_owner = ARB_OWNER_INST;
                if (!inst_req || sram_addr_ok) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_LOCK_DATA: begin
                gnt_vld   = 1'b1;
                gnt_owner = ARB_OWNER_DATA;
                if (!data_req || sram_addr_ok) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_IDLE: begin
                if (!full && (inst_req || data_req)) begin
                    gnt_vld   = 1'b1;
                    gnt_owner = (inst_req && data_req) ? rr_pick
                                                       : data_req;
                    if (!sram_addr_ok) begin
                        state_d = gnt_owner ? ARB_LOCK_DATA
                                            : ARB_LOCK_INST;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign gnt_cmd = !gnt_vld  ? '0       :
                     gnt_owner ? data_cmd : inst_cmd;

    assign sram_req   = gnt_cmd.req && !full;
    assign sram_wr    = gnt_cmd.wr;
    assign sram_size  = gnt_cmd.size;
    assign sram_wstrb = gnt_cmd.wstrb;
    assign sram_addr  = gnt_cmd.addr;
    assign sram_wdata = gnt_cmd.wdata;

    assign push = sram_req && sram_addr_ok;
    assign pop  = sram_data_ok && !empty;

    assign inst_addr_ok = push && (gnt_owner == ARB_OWNER_INST);
    assign data_addr_ok = push && (gnt_owner == ARB_OWNER_DATA);
    assign inst_data_ok = pop && (head == ARB_OWNER_INST);
    assign data_data_ok = pop && (head == ARB_OWNER_DATA);
    assign inst_rdata   = sram_rdata;
    assign data_rdata   = sram_rdata;

    arb_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .din    (gnt_owner),
        .pop    (sram_data_ok),
        .full   (full),
        .empty  (empty),
        .head   (head)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed and random stimulus for sram_like_arbiter against a queue model.
// Honours SRAM_ARB_RR_EN to select the expected contention policy.
module tb_sram_like_arbiter;

    localparam int OUT = 4;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_req, sram_wr;
    logic [1:0]  sram_size;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_addr, sram_wdata;
    logic        sram_addr_ok, sram_data_ok;
    logic [31:0] sram_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    // behavioural model: owner queue, locked owner (-1 none), last winner
    bit q[$];
    int lock_own = -1;
    bit last_g   = 1'b0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.OUTSTANDING(OUT)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
        .sram_wstrb(sram_wstrb), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_addr_ok(sram_addr_ok),
        .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_wstrb = 0;
        inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0;
        data_addr = 0; data_wdata = 0;
        sram_addr_ok = 0; sram_data_ok = 0; sram_rdata = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".sram_req"},   32'(sram_req),   0);
        chk({tag, ".sram_wr"},    32'(sram_wr),    0);
        chk({tag, ".sram_size"},  32'(sram_size),  0);
        chk({tag, ".sram_wstrb"}, 32'(sram_wstrb), 0);
        chk({tag, ".sram_addr"},  sram_addr,       0);
        chk({tag, ".sram_wdata"}, sram_wdata,      0);
        chk({tag, ".i_aok"},      32'(inst_addr_ok), 0);
        chk({tag, ".d_aok"},      32'(data_addr_ok), 0);
        chk({tag, ".i_dok"},      32'(inst_data_ok), 0);
        chk({tag, ".d_dok"},      32'(data_data_ok), 0);
        chk({tag, ".i_rdata"},    inst_rdata, 0);
        chk({tag, ".d_rdata"},    data_rdata, 0);
    endtask

    // one clock cycle: predict, compare mid-cycle, advance the model
    task automatic step(input string tag);
        bit full, gv, g, greq, sreq, acc, hv;
        @(negedge clk);
        #1;
        full = (q.size() == OUT);
        gv = 0; g = 0;
        if (lock_own >= 0) begin
            gv = 1; g = bit'(lock_own);
        end else if (!full && (inst_req || data_req)) begin
            gv = 1;
            if (inst_req && data_req) g = RR ? !last_g : 1'b1;
            else                      g = data_req;
        end
        greq = g ? data_req : inst_req;
        sreq = gv && greq && !full;
        acc  = sreq && sram_addr_ok;
        hv   = sram_data_ok && (q.size() > 0);
        chk({tag, ".sram_req"}, 32'(sram_req), 32'(sreq));
        chk({tag, ".sram_addr"}, sram_addr,
            !gv ? 32'h0 : (g ? data_addr : inst_addr));
        chk({tag, ".sram_wdata"}, sram_wdata,
            !gv ? 32'h0 : (g ? data_wdata : inst_wdata));
        chk({tag, ".sram_ctl"}, 32'({sram_wr, sram_size, sram_wstrb}),
            !gv ? 32'h0 : (g ? 32'({data_wr, data_size, data_wstrb})
                             : 32'({inst_wr, inst_size, inst_wstrb})));
        chk({tag, ".i_aok"}, 32'(inst_addr_ok), 32'(acc && !g));
        chk({tag, ".d_aok"}, 32'(data_addr_ok), 32'(acc && g));
        chk({tag, ".i_dok"}, 32'(inst_data_ok), 32'(hv && !q[0]));
        chk({tag, ".d_dok"}, 32'(data_data_ok), 32'(hv && q[0]));
        chk({tag, ".i_rdata"}, inst_rdata, sram_rdata);
        chk({tag, ".d_rdata"}, data_rdata, sram_rdata);
        if (hv) void'(q.pop_front());
        if (acc) begin
            q.push_back(g);
            last_g = g;
        end
        if (lock_own < 0) begin
            if (gv && sreq && !sram_addr_ok) lock_own = int'(g);
        end else if (!greq || acc) begin
            lock_own = -1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        resetn = 0;
        #3;
        check_zero("reset");
        @(negedge clk);
        resetn = 1;
        @(posedge clk);
        #1;

        // lone inst read, response two cycles after acceptance
        inst_req = 1; inst_addr = 32'hbfc00000; inst_size = 2;
        sram_addr_ok = 1;
        step("ir_acc");
        chk("ir_acc_q", 32'(q.size()), 1);
        inst_req = 0; sram_addr_ok = 0;
        step("ir_gap");
        sram_data_ok = 1; sram_rdata = 32'h3c080001;
        step("ir_resp");
        idle_inputs();
        step("ir_idle");

        // contention, then inst alone, then drain in order
        inst_req = 1; inst_addr = 32'h1000;
        data_req = 1; data_addr = 32'h2000; data_wr = 1;
        data_wstrb = 4'hf; data_wdata = 32'h55aa55aa;
        sram_addr_ok = 1;
        step("ct_1");
        step("ct_2");
        data_req = 0;
        step("ct_3");
        idle_inputs();
        sram_data_ok = 1; sram_rdata = 32'h11111111;
        step("ct_r1");
        sram_rdata = 32'h22222222;
        step("ct_r2");
        sram_rdata = 32'h33333333;
        step("ct_r3");
        idle_inputs();

        // slave stalls an inst request while data waits
        inst_req = 1; inst_addr = 32'hbfc00100;
        step("lk_start");
        data_req = 1; data_addr = 32'h8000_0040;
        for (int i = 0; i < 3; i++) step("lk_hold");
        chk("lk_state", 32'(lock_own), 0);
        sram_addr_ok = 1;
        step("lk_acc");
        inst_req = 0;
        step("lk_data");
        idle_inputs();
        sram_data_ok = 1;
        step("lk_r1");
        step("lk_r2");
        idle_inputs();

        // fill the tracker; a pop while full does not admit a request
        data_req = 1; data_addr = 32'h3000; sram_addr_ok = 1;
        for (int i = 0; i < OUT; i++) step("fl_fill");
        step("fl_full");
        sram_data_ok = 1;
        step("fl_pop");
        sram_data_ok = 0;
        step("fl_refill");
        step("fl_full2");
        idle_inputs();
        sram_data_ok = 1;
        step("fl_d1");
        step("fl_d2");
        idle_inputs();

        // asynchronous reset with two requests outstanding
        chk("rs_q", 32'(q.size()), 2);
        #2;
        resetn = 0;
        #1;
        q.delete();
        lock_own = -1;
        last_g   = 1'b0;
        check_zero("rs_async");
        @(negedge clk);
        resetn = 1;
        @(posedge clk);
        #1;

        // spurious response on an empty tracker, then refill from zero
        sram_data_ok = 1; sram_rdata = 32'hdeadbeef;
        step("sp_dok");
        idle_inputs();
        data_req = 1; sram_addr_ok = 1;
        for (int i = 0; i <= OUT; i++) step("sp_fill");
        idle_inputs();
        sram_data_ok = 1;
        for (int i = 0; i < OUT; i++) step("sp_drain");
        idle_inputs();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            inst_req     = ($urandom_range(0, 3) != 0);
            inst_wr      = 1'($urandom);
            inst_size    = 2'($urandom);
            inst_wstrb   = 4'($urandom);
            inst_addr    = $urandom;
            inst_wdata   = $urandom;
            data_req     = ($urandom_range(0, 2) != 0);
            data_wr      = 1'($urandom);
            data_size    = 2'($urandom);
            data_wstrb   = 4'($urandom);
            data_addr    = $urandom;
            data_wdata   = $urandom;
            sram_addr_ok = 1'($urandom);
            sram_data_ok = ($urandom_range(0, 2) == 0);
            sram_rdata   = $urandom;
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
